// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit hex counter feeding a seven-segment decoder.
// Supports parallel load, up/down stepping, and tick/wrap strobes.
module hex_digit_counter #(
    parameter int CNT_W   = 28,
    parameter int PERIOD1 = 50_000_000,
    parameter int PERIOD2 = 100_000_000,
    parameter int PERIOD3 = 200_000_000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       up,
    output logic [3:0] digit,
    output logic       tick,
    output logic       wrap
);

    localparam logic [CNT_W-1:0] P1_M1 = CNT_W'(PERIOD1 - 1);
    localparam logic [CNT_W-1:0] P2_M1 = CNT_W'(PERIOD2 - 1);
    localparam logic [CNT_W-1:0] P3_M1 = CNT_W'(PERIOD3 - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] reload_new;
    logic [CNT_W-1:0] reload_cur;
    logic [3:0]       digit_step;
    logic             wrap_step;

    function automatic logic [CNT_W-1:0] period_m1(input logic [1:0] s);
        logic [CNT_W-1:0] r;
        case (s)
            2'b00:   r = '0;
            2'b01:   r = P1_M1;
            2'b10:   r = P2_M1;
            default: r = P3_M1;
        endcase
        return r;
    endfunction

    always_comb begin
        reload_new = period_m1(speed);
        reload_cur = period_m1(speed_q);
        digit_step = up ? digit + 4'd1 : digit - 4'd1;
        wrap_step  = up ? (digit == 4'hF) : (digit == 4'h0);
    end

    // Load beats speed change, which beats the enable/step path.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digit   <= 4'h0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            speed_q <= 2'b01;
            cnt     <= P1_M1;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                digit   <= load_value;
                speed_q <= speed;
                cnt     <= reload_new;
            end else if (speed != speed_q) begin
                speed_q <= speed;
                cnt     <= reload_new;
            end else if (enable) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    cnt   <= reload_cur;
                    digit <= digit_step;
                    tick  <= 1'b1;
                    wrap  <= wrap_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed self-checking bench for hex_digit_counter with short periods
// (4/8/16 cycles) so every pacing case fits in a few hundred clocks.
module tb_hex_digit_counter;

    logic       clock;
    logic       resetn;
    logic       enable;
    logic [1:0] speed;
    logic       load;
    logic [3:0] load_value;
    logic       up;
    logic [3:0] digit;
    logic       tick;
    logic       wrap;

    int n_checks = 0;
    int n_passed = 0;

    hex_digit_counter #(
        .CNT_W  (5),
        .PERIOD1(4),
        .PERIOD2(8),
        .PERIOD3(16)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .enable    (enable),
        .speed     (speed),
        .load      (load),
        .load_value(load_value),
        .up        (up),
        .digit     (digit),
        .tick      (tick),
        .wrap      (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] d, input logic t, input logic w);
        chk({tag, ".digit"}, digit, d);
        chk({tag, ".tick"}, {3'b0, tick}, {3'b0, t});
        chk({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; speed = 2'b01; load = 1'b0;
        load_value = 4'h0; up = 1'b1;
        edges(2);
        chk3("reset", 4'h0, 1'b0, 1'b0);
        resetn = 1'b1;

        // reset then step at period 4
        edges(3); chk3("run_e3", 4'h0, 1'b0, 1'b0);
        edges(1); chk3("run_e4", 4'h1, 1'b1, 1'b0);
        edges(1); chk3("run_e5", 4'h1, 1'b0, 1'b0);
        edges(3); chk3("run_e8", 4'h2, 1'b1, 1'b0);
        edges(4); chk3("run_e12", 4'h3, 1'b1, 1'b0);

        // wrap up at speed 00
        load = 1'b1; load_value = 4'hE; speed = 2'b00; up = 1'b1;
        edges(1); chk3("wup_load", 4'hE, 1'b0, 1'b0);
        load = 1'b0;
        edges(1); chk3("wup_F", 4'hF, 1'b1, 1'b0);
        edges(1); chk3("wup_0", 4'h0, 1'b1, 1'b1);
        edges(1); chk3("wup_1", 4'h1, 1'b1, 1'b0);

        // wrap down
        load = 1'b1; load_value = 4'h1; up = 1'b0;
        edges(1); chk3("wdn_load", 4'h1, 1'b0, 1'b0);
        load = 1'b0;
        edges(1); chk3("wdn_0", 4'h0, 1'b1, 1'b0);
        edges(1); chk3("wdn_F", 4'hF, 1'b1, 1'b1);
        edges(1); chk3("wdn_E", 4'hE, 1'b1, 1'b0);

        // enable pause at speed 10
        load = 1'b1; load_value = 4'h0; speed = 2'b10; up = 1'b1;
        edges(1); chk3("pause_load", 4'h0, 1'b0, 1'b0);
        load = 1'b0;
        edges(3);
        enable = 1'b0;
        edges(20); chk3("pause_hold", 4'h0, 1'b0, 1'b0);
        enable = 1'b1;
        edges(4); chk3("pause_r4", 4'h0, 1'b0, 1'b0);
        edges(1); chk3("pause_r5", 4'h1, 1'b1, 1'b0);

        // speed change mid-period: 11 -> 01 at cnt=9
        load = 1'b1; load_value = 4'h0; speed = 2'b11;
        edges(1);
        load = 1'b0;
        edges(6);
        speed = 2'b01;
        edges(1); chk3("spd_change", 4'h0, 1'b0, 1'b0);
        edges(3); chk3("spd_c3", 4'h0, 1'b0, 1'b0);
        edges(1); chk3("spd_c4", 4'h1, 1'b1, 1'b0);

        // load collides with due step
        edges(3); chk3("col_pre", 4'h1, 1'b0, 1'b0);
        load = 1'b1; load_value = 4'h7;
        edges(1); chk3("col_load", 4'h7, 1'b0, 1'b0);
        load = 1'b0;
        edges(3); chk3("col_p3", 4'h7, 1'b0, 1'b0);
        edges(1); chk3("col_p4", 4'h8, 1'b1, 1'b0);

        // async reset mid-count
        load = 1'b1; load_value = 4'hA;
        edges(1); chk3("ar_load", 4'hA, 1'b0, 1'b0);
        load = 1'b0;
        edges(2);
        #2;
        resetn = 1'b0;
        #1;
        chk3("ar_async", 4'h0, 1'b0, 1'b0);
        edges(1);
        speed = 2'b10;
        resetn = 1'b1;
        edges(1); chk3("ar_spd_edge", 4'h0, 1'b0, 1'b0);
        edges(7); chk3("ar_p7", 4'h0, 1'b0, 1'b0);
        edges(1); chk3("ar_p8", 4'h1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
